// File: rtl/core_ctrl.sv
// Tile-pass sequencer for the PE core: loads weights and activations into xmem,
// streams them through L0 and the PE array, then drains the output FIFO into pmem.
module core_ctrl #(
  parameter int row   = 8,
  parameter int col   = 8,
  parameter int n_act = 36
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [10:0] w_base,
  input  logic [10:0] a_base,
  input  logic [10:0] p_base,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        ofifo_valid,
  output logic [33:0] inst,
  output logic [31:0] D_xmem,
  output logic        busy,
  output logic        done
);

  localparam int CW = 16;
  localparam logic [CW-1:0] ROW_N     = CW'(row);
  localparam logic [CW-1:0] ROW_LAST  = CW'(row - 1);
  localparam logic [CW-1:0] ACT_N     = CW'(n_act);
  localparam logic [CW-1:0] ACT_LAST  = CW'(n_act - 1);
  localparam logic [CW-1:0] LOAD_LEN  = CW'(row + col - 1);
  localparam logic [CW-1:0] EXEC_LAST = CW'(n_act + row + col - 2);
  localparam logic [33:0]   IDLE_WORD = 34'h1800C0000;

  typedef enum logic [2:0] {
    IDLE, WLOAD, ALOAD, WL0, KLOAD, EXEC, DRAIN, DONE
  } state_t;

  state_t          state, next_state;
  logic [CW-1:0]   cnt, next_cnt;
  logic [CW-1:0]   rd_cnt, next_rd_cnt;
  logic            rd_pend, next_rd_pend;
  logic [10:0]     w_base_q, a_base_q, p_base_q;
  logic [33:0]     next_inst;
  logic [31:0]     next_d_xmem;

  logic            cen_p, wen_p, cen_x, wen_x;
  logic [10:0]     a_p, a_x;
  logic            ofifo_rd, l0_rd, l0_wr, exe, ld;
  logic            handshake;

  assign in_ready  = (state == WLOAD) || (state == ALOAD);
  assign handshake = in_valid && in_ready;

  always_comb begin
    next_state   = state;
    next_cnt     = cnt;
    next_rd_cnt  = rd_cnt;
    next_rd_pend = 1'b0;
    next_d_xmem  = D_xmem;
    cen_p        = 1'b1;
    wen_p        = 1'b1;
    a_p          = 11'd0;
    cen_x        = 1'b1;
    wen_x        = 1'b1;
    a_x          = 11'd0;
    ofifo_rd     = 1'b0;
    l0_rd        = 1'b0;
    l0_wr        = 1'b0;
    exe          = 1'b0;
    ld           = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          next_state = WLOAD;
          next_cnt   = '0;
        end
      end

      WLOAD: begin
        if (handshake) begin
          cen_x       = 1'b0;
          wen_x       = 1'b0;
          a_x         = w_base_q + cnt[10:0];
          next_d_xmem = in_data;
          if (cnt == ROW_LAST) begin
            next_state = ALOAD;
            next_cnt   = '0;
          end else begin
            next_cnt = cnt + 1'b1;
          end
        end
      end

      ALOAD: begin
        if (handshake) begin
          cen_x       = 1'b0;
          wen_x       = 1'b0;
          a_x         = a_base_q + cnt[10:0];
          next_d_xmem = in_data;
          if (cnt == ACT_LAST) begin
            next_state = WL0;
            next_cnt   = '0;
          end else begin
            next_cnt = cnt + 1'b1;
          end
        end
      end

      // One extra cycle past the last read so the final word lands in L0.
      WL0: begin
        if (cnt < ROW_N) begin
          cen_x = 1'b0;
          a_x   = w_base_q + cnt[10:0];
        end
        l0_wr = (cnt != '0);
        if (cnt == ROW_N) begin
          next_state = KLOAD;
          next_cnt   = '0;
        end else begin
          next_cnt = cnt + 1'b1;
        end
      end

      KLOAD: begin
        if (cnt < LOAD_LEN) begin
          l0_rd = 1'b1;
          ld    = 1'b1;
        end
        if (cnt == LOAD_LEN) begin
          next_state = EXEC;
          next_cnt   = '0;
        end else begin
          next_cnt = cnt + 1'b1;
        end
      end

      EXEC: begin
        if (cnt < ACT_N) begin
          cen_x = 1'b0;
          a_x   = a_base_q + cnt[10:0];
        end
        l0_wr = (cnt != '0) && (cnt <= ACT_N);
        exe   = (cnt != '0);
        l0_rd = (cnt != '0);
        if (cnt == EXEC_LAST) begin
          next_state  = DRAIN;
          next_cnt    = '0;
          next_rd_cnt = '0;
        end else begin
          next_cnt = cnt + 1'b1;
        end
      end

      // Reads and pmem writes overlap: the write for vector j shares a word with the read of j+1.
      DRAIN: begin
        if (ofifo_valid && (rd_cnt < ACT_N)) begin
          ofifo_rd     = 1'b1;
          next_rd_pend = 1'b1;
          next_rd_cnt  = rd_cnt + 1'b1;
        end
        if (rd_pend) begin
          cen_p = 1'b0;
          wen_p = 1'b0;
          a_p   = p_base_q + cnt[10:0];
          if (cnt == ACT_LAST) begin
            next_state = DONE;
            next_cnt   = '0;
          end else begin
            next_cnt = cnt + 1'b1;
          end
        end
      end

      DONE: begin
        next_state = IDLE;
      end

      default: begin
        next_state = IDLE;
      end
    endcase

    next_inst = {1'b0, cen_p, wen_p, a_p, cen_x, wen_x, a_x,
                 ofifo_rd, 1'b0, 1'b0, l0_rd, l0_wr, exe, ld};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      rd_cnt   <= '0;
      rd_pend  <= 1'b0;
      w_base_q <= '0;
      a_base_q <= '0;
      p_base_q <= '0;
      inst     <= IDLE_WORD;
      D_xmem   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state   <= next_state;
      cnt     <= next_cnt;
      rd_cnt  <= next_rd_cnt;
      rd_pend <= next_rd_pend;
      inst    <= next_inst;
      D_xmem  <= next_d_xmem;
      busy    <= (next_state != IDLE) || (state == DONE);
      done    <= (state == DONE);
      if ((state == IDLE) && start) begin
        w_base_q <= w_base;
        a_base_q <= a_base;
        p_base_q <= p_base;
      end
    end
  end

endmodule

// File: tb/tb_core_ctrl.sv
// Randomized scoreboard bench for core_ctrl: the driver queues expected SRAM traffic,
// a monitor one delta after each rising edge pops and compares what the core emits.
module tb_core_ctrl;

  localparam int ROW    = 8;
  localparam int COL    = 8;
  localparam int N      = 36;
  localparam int LOAD_N = ROW + COL - 1;
  localparam int EXEC_N = N + ROW + COL - 2;
  localparam logic [33:0] IDLE_W = 34'h1800C0000;

  typedef struct {
    logic [10:0] a;
    logic [31:0] d;
  } wr_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic [10:0] w_base, a_base, p_base;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        ofifo_valid;
  logic [33:0] inst;
  logic [31:0] D_xmem;
  logic        busy;
  logic        done;

  core_ctrl #(.row(ROW), .col(COL), .n_act(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .w_base      (w_base),
    .a_base      (a_base),
    .p_base      (p_base),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .ofifo_valid (ofifo_valid),
    .inst        (inst),
    .D_xmem      (D_xmem),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  wr_t         exp_w_q[$];
  logic [10:0] exp_rd_q[$];
  logic [10:0] exp_p_q[$];

  // Driver-to-monitor flags describing the rising edge that follows each falling edge.
  bit drv_hs  = 1'b0;
  bit feeding = 1'b0;

  int load_seen, exec_seen, load_runs, exec_runs, model_rd, pmem_seen;
  int done_total = 0;
  bit drain_phase, prev_read, prev_load, prev_exec, prev_exp_rd, last_write_prev;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic note_fail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got nothing expected event at %0t", name, $time);
  endtask

  task automatic clear_pass();
    load_seen = 0; exec_seen = 0; load_runs = 0; exec_runs = 0;
    model_rd = 0; pmem_seen = 0; drain_phase = 0;
    prev_read = 0; prev_load = 0; prev_exec = 0; prev_exp_rd = 0; last_write_prev = 0;
  endtask

  // Monitor: decodes each emitted instruction word and scores it against the queued model.
  bit  w_pres, r_pres, p_pres, exp_rd, this_last;
  wr_t we;
  logic [10:0] ea;

  always @(posedge clk) begin
    #1;
    if (!reset) begin
      check_output("reset_inst", 64'(inst), 64'(IDLE_W));
      check_output("reset_busy", 64'(busy), 64'd0);
      exp_w_q.delete();
      exp_rd_q.delete();
      exp_p_q.delete();
      clear_pass();
    end else begin
      w_pres = !inst[19] && !inst[18];
      r_pres = !inst[19] &&  inst[18];
      p_pres = !inst[32] && !inst[31];

      check_output("xmem_wr_vs_handshake", 64'(w_pres), 64'(drv_hs));
      if (w_pres) begin
        if (exp_w_q.size() == 0) note_fail("xmem_wr_unexpected");
        else begin
          we = exp_w_q.pop_front();
          check_output("xmem_wr_addr", 64'(inst[17:7]), 64'(we.a));
          check_output("xmem_wr_data", 64'(D_xmem), 64'(we.d));
        end
      end
      if (feeding && !drv_hs) check_output("stall_idle_word", 64'(inst), 64'(IDLE_W));

      if (r_pres) begin
        if (exp_rd_q.size() == 0) note_fail("xmem_rd_unexpected");
        else begin
          ea = exp_rd_q.pop_front();
          check_output("xmem_rd_addr", 64'(inst[17:7]), 64'(ea));
        end
      end
      check_output("l0_wr_lag", 64'(inst[2]), 64'(prev_read));
      check_output("fixed_zero_bits", 64'({inst[33], inst[5], inst[4]}), 64'd0);

      if (inst[0]) begin
        load_seen++;
        if (!prev_load) load_runs++;
      end
      if (prev_load && !inst[0]) check_output("kload_gap", 64'(inst), 64'(IDLE_W));
      if (inst[1]) begin
        exec_seen++;
        if (!prev_exec) begin
          exec_runs++;
          check_output("exec_first_l0wr", 64'(inst[2]), 64'd1);
        end
        if (exec_seen == EXEC_N) drain_phase = 1'b1;
      end
      if (inst[0] || inst[1]) check_output("l0_rd_with_pe", 64'(inst[3]), 64'd1);

      exp_rd = drain_phase && ofifo_valid && (model_rd < N);
      check_output("ofifo_rd", 64'(inst[6]), 64'(exp_rd));
      check_output("pmem_wr_follows_rd", 64'(p_pres), 64'(prev_exp_rd));
      this_last = 1'b0;
      if (p_pres) begin
        if (exp_p_q.size() == 0) note_fail("pmem_wr_unexpected");
        else begin
          ea = exp_p_q.pop_front();
          check_output("pmem_addr", 64'(inst[30:20]), 64'(ea));
        end
        pmem_seen++;
        this_last = (pmem_seen == N);
      end
      if (exp_rd) model_rd++;

      check_output("done_timing", 64'(done), 64'(last_write_prev));
      if (inst !== IDLE_W || done) check_output("busy_active", 64'(busy), 64'd1);

      prev_read       = r_pres;
      prev_load       = inst[0];
      prev_exec       = inst[1];
      prev_exp_rd     = exp_rd;
      last_write_prev = this_last;

      if (done) begin
        check_output("load_cycles", 64'(load_seen), 64'(LOAD_N));
        check_output("exec_cycles", 64'(exec_seen), 64'(EXEC_N));
        check_output("load_runs", 64'(load_runs), 64'd1);
        check_output("exec_runs", 64'(exec_runs), 64'd1);
        check_output("pmem_count", 64'(pmem_seen), 64'(N));
        check_output("reads_left", 64'(exp_rd_q.size()), 64'd0);
        done_total++;
        clear_pass();
      end
    end
  end

  // One tile pass: start, host stream, then either drain to completion or abort mid-EXEC.
  task automatic apply_stimulus(input logic [10:0] w, input logic [10:0] a, input logic [10:0] p,
                                input int vmode, input int omode, input bit abort, input bit seq_data);
    int   i, cyc, d0;
    logic v;
    wr_t  e;
    @(negedge clk);
    w_base = w; a_base = a; p_base = p; start = 1'b1;
    for (int k = 0; k < ROW; k++) exp_rd_q.push_back(w + 11'(k));
    for (int k = 0; k < N; k++) begin
      exp_rd_q.push_back(a + 11'(k));
      exp_p_q.push_back(p + 11'(k));
    end
    @(negedge clk);
    start = 1'b0;
    w_base = 11'($urandom); a_base = 11'($urandom); p_base = 11'($urandom);

    i = 0; cyc = 0;
    while (i < ROW + N && cyc < 2000) begin
      feeding = 1'b1;
      start   = (cyc == 3);
      case (vmode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(3) != 0);
      endcase
      in_valid = v;
      in_data  = seq_data ? 32'(i) : $urandom;
      drv_hs   = v && in_ready;
      if (drv_hs) begin
        e.a = (i < ROW) ? w + 11'(i) : a + 11'(i - ROW);
        e.d = in_data;
        exp_w_q.push_back(e);
        i++;
      end
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0; drv_hs = 1'b0; feeding = 1'b0; start = 1'b0;
    if (i < ROW + N) note_fail("feed_timeout");

    if (abort) begin
      cyc = 0;
      while (exec_seen < 20 && cyc < 1000) begin
        @(negedge clk);
        cyc++;
      end
      if (exec_seen < 20) note_fail("exec_wait_timeout");
      reset = 1'b0;
      #1;
      check_output("abort_inst", 64'(inst), 64'(IDLE_W));
      check_output("abort_busy", 64'(busy), 64'd0);
      check_output("abort_done", 64'(done), 64'd0);
      check_output("abort_in_ready", 64'(in_ready), 64'd0);
      check_output("abort_d_xmem", 64'(D_xmem), 64'd0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
    end else begin
      cyc = 0;
      while (!drain_phase && cyc < 1000) begin
        @(negedge clk);
        cyc++;
      end
      if (!drain_phase) note_fail("drain_wait_timeout");
      d0 = done_total; cyc = 0;
      while (done_total == d0 && cyc < 2000) begin
        ofifo_valid = (omode == 1) ? 1'b1 : 1'($urandom_range(1));
        @(negedge clk);
        cyc++;
      end
      ofifo_valid = 1'b0;
      if (done_total == d0) note_fail("done_timeout");
      repeat (3) @(negedge clk);
      check_output("done_once", 64'(done_total), 64'(d0 + 1));
    end
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; ofifo_valid = 1'b0;
    w_base = '0; a_base = '0; p_base = '0;
    clear_pass();
    repeat (3) @(negedge clk);
    check_output("init_d_xmem", 64'(D_xmem), 64'd0);
    check_output("init_in_ready", 64'(in_ready), 64'd0);
    reset = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check_output("idle_inst", 64'(inst), 64'(IDLE_W));
      check_output("idle_busy", 64'(busy), 64'd0);
      check_output("idle_in_ready", 64'(in_ready), 64'd0);
    end

    $display("[TB] pass 1: back-to-back host words, pmem wrap at 2040");
    apply_stimulus(11'd0, 11'd8, 11'd2040, 0, 1, 1'b0, 1'b1);
    $display("[TB] pass 2: toggling in_valid, random ofifo_valid");
    apply_stimulus(11'($urandom), 11'($urandom), 11'($urandom), 1, 0, 1'b0, 1'b0);
    $display("[TB] pass 3: reset mid-EXEC");
    apply_stimulus(11'($urandom), 11'($urandom), 11'($urandom), 2, 0, 1'b1, 1'b0);
    $display("[TB] pass 4: restart after abort");
    apply_stimulus(11'($urandom), 11'($urandom), 11'($urandom), 2, 1, 1'b0, 1'b0);
    $display("[TB] pass 5: xmem address wrap");
    apply_stimulus(11'd2044, 11'd2030, 11'($urandom), 2, 0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check_output("final_busy", 64'(busy), 64'd0);
    check_output("final_done_total", 64'(done_total), 64'd4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish expected finish by 500000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/core_ctrl.md
CORE_CTRL -- requirements
Module: core_ctrl

Interface
REQ-001 Parameter row, default 8: PE array rows, and the weight-word count loaded per tile.
REQ-002 Parameter col, default 8: PE array columns, and the output-vector count per activation.
REQ-003 Parameter n_act, default 36: activation vectors per tile.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  single-cycle pulse; begins one tile pass, honoured only in IDLE.
REQ-007 w_base, a_base, p_base  input  11 each  xmem weight base, xmem activation base, pmem base; sampled on accepted start.
REQ-008 in_valid / in_ready / in_data  input / output / input  1 / 1 / 32  host write stream to xmem.
REQ-009 ofifo_valid  input  1  core output FIFO holds a result vector.
REQ-010 inst  output  34  core instruction word; bit map: 33 acc, 32 CEN_pmem, 31 WEN_pmem, 30:20 A_pmem, 19 CEN_xmem, 18 WEN_xmem, 17:7 A_xmem, 6 ofifo_rd, 5 ififo_wr, 4 ififo_rd, 3 l0_rd, 2 l0_wr, 1 execute, 0 load.
REQ-011 D_xmem  output  32  xmem write data.
REQ-012 busy / done  output  1 / 1  pass in progress / one-cycle completion pulse.

Function
REQ-013 All outputs except in_ready SHALL be registered; in_ready SHALL be combinational from state only (high in WLOAD and ALOAD).
REQ-014 Idle word: CEN and WEN bits = 1, all other bits 0 (34'h1800C0000); driven whenever no other field is active.
REQ-015 FSM SHALL follow IDLE -> WLOAD -> ALOAD -> WL0 -> KLOAD -> EXEC -> DRAIN -> DONE -> IDLE, no skips.
REQ-016 WLOAD: per in_valid&&in_ready handshake, next cycle inst gets CEN_xmem=0, WEN_xmem=0, A_xmem=w_base+k, D_xmem=in_data; k counts 0..row-1; exit after handshake row-1; stalls on in_valid=0 insert the idle word.
REQ-017 ALOAD: same, with A_xmem=a_base+k, k 0..n_act-1.
REQ-018 WL0: row consecutive xmem reads (CEN=0, WEN=1, A=w_base+k); l0_wr=1 exactly one cycle after each read (SRAM read latency 1), so l0_wr spans row cycles lagging reads by 1.
REQ-019 KLOAD: l0_rd=1 and load=1 for row+col-1 cycles, then one idle-word gap cycle.
REQ-020 EXEC: n_act xmem reads from a_base; l0_wr one cycle after each read; l0_rd=1 and execute=1 from first l0_wr for n_act+row+col-2 cycles.
REQ-021 DRAIN: each cycle with ofifo_valid=1 asserts ofifo_rd=1; the following cycle writes pmem (CEN_pmem=0, WEN_pmem=0, A_pmem=p_base+j), j 0..n_act-1; ofifo_valid=0 inserts idle cycles; exit after write n_act-1.
REQ-022 ofifo_rd and pmem write of consecutive vectors SHALL overlap (back-to-back valid yields one vector per cycle).
REQ-023 DONE: done=1 for one cycle, idle word; busy=1 in all states except IDLE.
REQ-024 start outside IDLE SHALL be ignored; base addresses SHALL not change mid-pass.
REQ-025 Address arithmetic SHALL be 11-bit modulo 2048 (base+k wraps, no error).
REQ-026 acc (bit 33), ififo_wr and ififo_rd SHALL be held 0.

Reset
REQ-027 reset low SHALL asynchronously force IDLE, all counters 0, inst=34'h1800C0000, D_xmem=0, busy=0, done=0, in_ready=0.
REQ-028 Reset mid-pass SHALL abort immediately with no further SRAM write; next start begins from WLOAD.

Verification
REQ-029 Reset then idle 5 cycles -> inst=34'h1800C0000, busy=0, in_ready=0 every cycle.
REQ-030 start, w_base=0, a_base=8, 44 back-to-back host words 0..43 -> xmem writes addr 0..43 with data 0..43, one per cycle.
REQ-031 in_valid toggling 1/0 during ALOAD -> idle word on each 0 cycle, addresses contiguous with no gaps.
REQ-032 WL0/KLOAD/EXEC -> l0_wr lags each read by exactly 1; load high 15 cycles; execute high 50 cycles (defaults).
REQ-033 ofifo_valid high 36 cycles, p_base=2040 -> pmem addresses 2040..2047,0..27 contiguous, then done pulse and IDLE.
REQ-034 reset asserted mid-EXEC, start reissued -> clean restart, pass completes, done pulses once.
